// File: rtl/game_pkg.sv
// Shared types and level constants for the wall-increase border logic.
package game_pkg;

  localparam int unsigned BW      = 4;
  localparam int unsigned SCORE_W = 8;

  typedef struct packed {
    logic [BW-1:0] xmax;
    logic [BW-1:0] xmin;
    logic [BW-1:0] ymax;
    logic [BW-1:0] ymin;
  } border_t;

  typedef enum logic [2:0] {IDLE, SETTLED, WAIT, CHECK, COMMIT} border_state_t;

  // Score thresholds (strictly greater than) and the border each level unlocks.
  localparam logic [SCORE_W-1:0] LVL6_SCORE = 8'd100;
  localparam logic [SCORE_W-1:0] LVL5_SCORE = 8'd80;
  localparam logic [SCORE_W-1:0] LVL4_SCORE = 8'd60;
  localparam logic [SCORE_W-1:0] LVL3_SCORE = 8'd40;
  localparam logic [SCORE_W-1:0] LVL2_SCORE = 8'd20;
  localparam logic [SCORE_W-1:0] LVL1_SCORE = 8'd10;

  localparam logic [BW-1:0] LVL6_X = 4'd15;
  localparam logic [BW-1:0] LVL6_Y = 4'd11;
  localparam logic [BW-1:0] LVL5_X = 4'd14;
  localparam logic [BW-1:0] LVL5_Y = 4'd10;
  localparam logic [BW-1:0] LVL4_X = 4'd13;
  localparam logic [BW-1:0] LVL4_Y = 4'd9;
  localparam logic [BW-1:0] LVL3_X = 4'd12;
  localparam logic [BW-1:0] LVL3_Y = 4'd8;
  localparam logic [BW-1:0] LVL2_X = 4'd10;
  localparam logic [BW-1:0] LVL2_Y = 4'd7;
  localparam logic [BW-1:0] LVL1_X = 4'd9;
  localparam logic [BW-1:0] LVL1_Y = 4'd7;
  localparam logic [BW-1:0] LVL0_X = 4'd8;
  localparam logic [BW-1:0] LVL0_Y = 4'd6;

endpackage

// File: rtl/border_level_lut.sv
// Combinational score-to-target-border table, shared with the level display.
module border_level_lut
  import game_pkg::*;
(
  input  logic [SCORE_W-1:0] score,
  output logic [BW-1:0]      tx_c,
  output logic [BW-1:0]      ty_c
);

  always_comb begin
    tx_c = LVL0_X;
    ty_c = LVL0_Y;
    if (score > LVL6_SCORE) begin
      tx_c = LVL6_X; ty_c = LVL6_Y;
    end else if (score > LVL5_SCORE) begin
      tx_c = LVL5_X; ty_c = LVL5_Y;
    end else if (score > LVL4_SCORE) begin
      tx_c = LVL4_X; ty_c = LVL4_Y;
    end else if (score > LVL3_SCORE) begin
      tx_c = LVL3_X; ty_c = LVL3_Y;
    end else if (score > LVL2_SCORE) begin
      tx_c = LVL2_X; ty_c = LVL2_Y;
    end else if (score > LVL1_SCORE) begin
      tx_c = LVL1_X; ty_c = LVL1_Y;
    end
  end

endmodule

// File: rtl/border_ctrl.sv
// Walks the live playfield border toward the score-derived target, one cell per
// snake move, with a collision check before any shrink.
module border_ctrl
  import game_pkg::*;
#(
  parameter int unsigned XFULL       = 15,
  parameter int unsigned YFULL       = 11,
  parameter int unsigned CHK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_in,
  input  logic [SCORE_W-1:0] score,
  input  logic               move_tick,
  input  logic               chk_ack,
  input  logic               chk_clear,
  output logic               chk_req,
  output logic [BW-1:0]      chk_xmax,
  output logic [BW-1:0]      chk_ymax,
  output logic [BW-1:0]      XMAX,
  output logic [BW-1:0]      XMIN,
  output logic [BW-1:0]      YMAX,
  output logic [BW-1:0]      YMIN,
  output logic               border_changed,
  output logic               busy,
  output logic               chk_err
);

  localparam int unsigned CNT_W = $clog2(CHK_TIMEOUT + 1);
  localparam border_t FULL = '{xmax: BW'(XFULL), xmin: '0, ymax: BW'(YFULL), ymin: '0};

  border_state_t   state;
  border_t         live;
  logic [CNT_W-1:0] cnt;
  logic [BW-1:0]   prop_x, prop_y;
  logic [BW-1:0]   tx, ty, nx, ny;
  logic            at_target, shrink, prop_at_target;

  border_level_lut u_lut (.score(score), .tx_c(tx), .ty_c(ty));

  // One-cell step toward the target on each axis independently.
  always_comb begin
    nx = live.xmax;
    ny = live.ymax;
    if (tx > live.xmax)      nx = live.xmax + BW'(1);
    else if (tx < live.xmax) nx = live.xmax - BW'(1);
    if (ty > live.ymax)      ny = live.ymax + BW'(1);
    else if (ty < live.ymax) ny = live.ymax - BW'(1);
    at_target      = (tx == live.xmax) && (ty == live.ymax);
    shrink         = (nx < live.xmax) || (ny < live.ymax);
    prop_at_target = (tx == prop_x) && (ty == prop_y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      live           <= FULL;
      cnt            <= '0;
      prop_x         <= '0;
      prop_y         <= '0;
      chk_req        <= 1'b0;
      chk_xmax       <= '0;
      chk_ymax       <= '0;
      border_changed <= 1'b0;
      busy           <= 1'b0;
      chk_err        <= 1'b0;
    end else begin
      border_changed <= 1'b0;
      chk_err        <= 1'b0;
      if (!enable_in) begin
        state          <= IDLE;
        live           <= FULL;
        chk_req        <= 1'b0;
        busy           <= 1'b0;
        border_changed <= (live != FULL);
      end else begin
        case (state)
          IDLE, SETTLED: begin
            if (at_target) begin
              state <= SETTLED;
              busy  <= 1'b0;
            end else begin
              state <= WAIT;
              busy  <= 1'b1;
            end
          end
          WAIT: begin
            if (at_target) begin
              state <= SETTLED;
              busy  <= 1'b0;
            end else if (move_tick) begin
              prop_x <= nx;
              prop_y <= ny;
              if (shrink) begin
                state    <= CHECK;
                chk_req  <= 1'b1;
                chk_xmax <= nx;
                chk_ymax <= ny;
                cnt      <= '0;
              end else begin
                state <= COMMIT;
              end
            end
          end
          CHECK: begin
            if (chk_ack) begin
              chk_req <= 1'b0;
              state   <= chk_clear ? COMMIT : WAIT;
            end else if (cnt >= CNT_W'(CHK_TIMEOUT - 1)) begin
              chk_req <= 1'b0;
              chk_err <= 1'b1;
              state   <= WAIT;
              cnt     <= CNT_W'(CHK_TIMEOUT);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          COMMIT: begin
            live.xmax      <= prop_x;
            live.ymax      <= prop_y;
            border_changed <= 1'b1;
            if (prop_at_target) begin
              state <= SETTLED;
              busy  <= 1'b0;
            end else begin
              state <= WAIT;
              busy  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign XMAX = live.xmax;
  assign XMIN = live.xmin;
  assign YMAX = live.ymax;
  assign YMIN = live.ymin;

endmodule

// File: doc/border_ctrl.md
Name: border_ctrl

Overview:
- Sequences the playfield border for the wall-increase game mode.
- Maps score to a target border, then walks the live border toward that target one cell per snake move.
- Before any shrink step, asks collision logic to confirm that no snake segment or apple lies in the cells being removed.
- Outputs XMAX/XMIN/YMAX/YMIN feed the renderer and the collision logic.

Parameters:
- XFULL, 15, full-field XMAX, used when disabled and at reset
- YFULL, 11, full-field YMAX, used when disabled and at reset
- CHK_TIMEOUT, 15, cycles to wait for chk_ack before aborting a check

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- enable_in  in  1  wall-increase mode active
- score  in  8  current score, unsigned
- move_tick  in  1  one-cycle pulse per snake step
- chk_ack  in  1  collision logic has answered the pending check
- chk_clear  in  1  valid with chk_ack; 1 = cells being removed are empty
- chk_req  out  1  check request, held until chk_ack
- chk_xmax  out  4  proposed XMAX, stable while chk_req=1
- chk_ymax  out  4  proposed YMAX, stable while chk_req=1
- XMAX, XMIN, YMAX, YMIN  out  4 each  live border, registered
- border_changed  out  1  one-cycle pulse when the live border updates
- busy  out  1  live border != target
- chk_err  out  1  one-cycle pulse on check timeout

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - XMAX=XFULL, XMIN=0, YMAX=YFULL, YMIN=0
  - chk_req=0, chk_xmax=0, chk_ymax=0
  - border_changed=0, busy=0, chk_err=0
  - state IDLE, timeout counter 0
- XMIN and YMIN are always 0 in this revision.
- Target table, combinational on score (strict >), as (tx,ty):
  - score>100: (15,11)
  - score>80: (14,10)
  - score>60: (13,9)
  - score>40: (12,8)
  - score>20: (10,7)
  - score>10: (9,7)
  - otherwise: (8,6)
- Step proposal: each axis moves independently by ±1 toward its target.
  - Example: nx = XMAX+1 if tx>XMAX; XMAX-1 if tx<XMAX; else XMAX. ny is derived the same way from YMAX.
  - A step is a shrink if nx<XMAX or ny<YMAX. Any shrink requires a check for the whole step.
- States:
  - IDLE: enable_in=0; outputs held at full field. enable_in=1 → SETTLED if target equals current, else WAIT.
  - SETTLED: busy=0. Target differs → WAIT.
  - WAIT: busy=1; wait for move_tick.
    - If target now equals current → SETTLED.
    - move_tick with a pure-grow step → COMMIT.
    - move_tick with a shrink step → CHECK; latch chk_xmax/chk_ymax=nx/ny; assert chk_req at the next edge.
  - CHECK: chk_req=1; counter increments each cycle.
    - chk_ack with chk_clear=1 → COMMIT using the latched proposal.
    - chk_ack with chk_clear=0 → WAIT; retry on the next move_tick, proposal recomputed.
    - Counter reaching CHK_TIMEOUT without ack → WAIT, chk_err pulse.
    - chk_req deasserts at the edge that leaves CHECK.
  - COMMIT: lasts one cycle.
    - At its closing edge, XMAX/YMAX load the proposal and border_changed=1 for exactly the next cycle.
    - Next state: SETTLED if the new border equals target, else WAIT.
- Latency: move_tick to new border is 2 cycles for a grow step, and 3 cycles + ack latency for a shrink step.
- Boundaries:
  - enable_in falls in any state: next edge forces the full field and IDLE; chk_req drops; border_changed pulses only if the border actually changed.
  - Score changes during CHECK: the latched proposal is unaffected; the target is re-evaluated after.
  - move_tick in CHECK or COMMIT: ignored, not queued.
  - chk_ack while chk_req=0: ignored.
  - The counter saturates; it clears on entry to CHECK.
  - Arithmetic is unsigned 4-bit. Table values are ≤15, so ±1 steps never wrap.
  - rst mid-check returns to reset values immediately.

Decomposition:
- Shared package game_pkg:
  - typedef border_t (xmax, xmin, ymax, ymin, each 4-bit)
  - FSM enum border_state_t {IDLE, SETTLED, WAIT, CHECK, COMMIT}
  - Score-threshold and bound constants
- One sub-module, border_level_lut: combinational score→(tx,ty) table, reusable by the renderer's level display.

Test Plan:
- Reset check: rst=1 mid-run, score=0, enable_in=1 → XMAX=15, YMAX=11, chk_req=0; after release, state WAIT, busy=1.
- Single clear shrink: score=0, enable_in=1, one move_tick, ack after 2 cycles with chk_clear=1 → chk_xmax=14, chk_ymax=10 while requesting; XMAX=14, YMAX=10, one border_changed pulse.
- Full shrink: continue the shrink scenario with 7 acked ticks → border reaches (8,6); after the 5th commit (ymax at 6), ymax is held and only x shrinks; busy=0, state SETTLED.
- Blocked check: chk_clear=0 → border unchanged, chk_req re-asserted only on the next move_tick.
- Timeout: no chk_ack → chk_err pulses 15 cycles after chk_req rises; chk_req drops; border unchanged.
- Grow on score: settled at (8,6), score jumps to 101 → pure-grow steps with no chk_req, one cell per tick, reaching (15,11) after 7 ticks.
- Disable mid-check: enable_in drops while chk_req=1 → next edge gives chk_req=0 and border (15,0,11,0).
